wo_bank: RTL and testbench

WO_BANK -- requirements
Module: wo_bank

---
 rtl/wo_bank_if.sv | 36 +++
 rtl/wo_bank.sv | 138 +++++++++++++
 tb/tb_wo_bank.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wo_bank_if.sv
// wo_bank port bundle: write port, burst request and read stream.
// master drives requests and rd_ready; slave is the weight bank.
interface wo_bank_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int NCH    = 1
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic                    clr;
   logic                    wr_en;
   logic [CHW-1:0]          wr_ch;
   logic [ADDR_W-1:0]       wr_addr;
   logic [DATA_W-1:0]       wr_data;
   logic                    start;
   logic [ADDR_W-1:0]       base;
   logic [ADDR_W:0]         len;
   logic                    rd_ready;
   logic                    rd_valid;
   logic [NCH*DATA_W-1:0]   rd_data;
   logic [ADDR_W-1:0]       rd_addr;
   logic                    busy;
   logic                    done;

   modport master (
      output clr, wr_en, wr_ch, wr_addr, wr_data,
      output start, base, len, rd_ready,
      input  rd_valid, rd_data, rd_addr, busy, done
   );

   modport slave (
      input  clr, wr_en, wr_ch, wr_addr, wr_data,
      input  start, base, len, rd_ready,
      output rd_valid, rd_data, rd_addr, busy, done
   );
endinterface

// File: rtl/wo_bank.sv
// Multi-channel weight bank with written flags and a burst read
// streamer (valid/ready) that wraps addresses modulo DEPTH.
module wo_bank #(
   parameter int               DATA_W  = 8,
   parameter int               ADDR_W  = 8,
   parameter int               NCH     = 1,
   parameter logic [DATA_W-1:0] DEF_VAL = DATA_W'(8'h02)
) (
   input  logic     CS,
   input  logic     cen,
   wo_bank_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST} state_t;

   logic [DATA_W-1:0]     r_mem [NCH][DEPTH];
   logic [DEPTH-1:0]      r_wf  [NCH];

   state_t                r_state;
   state_t                w_state_n;
   logic [ADDR_W-1:0]     r_ptr,   w_ptr_n;
   logic [ADDR_W:0]       r_rem,   w_rem_n;
   logic                  r_valid, w_valid_n;
   logic [NCH*DATA_W-1:0] r_data,  w_data_n;
   logic [ADDR_W-1:0]     r_addr,  w_addr_n;
   logic                  r_done,  w_done_n;
   logic [ADDR_W-1:0]     w_raddr;
   logic [NCH*DATA_W-1:0] w_rword;

   assign w_raddr = (r_state == S_IDLE) ? bus.base : r_ptr;

   // Word data storage; clr blocks a coincident write.
   always_ff @(posedge CS) begin
      for (int k = 0; k < NCH; k++) begin
         if (bus.wr_en && !bus.clr && bus.wr_ch == CHW'(k))
            r_mem[k][bus.wr_addr] <= bus.wr_data;
      end
   end

   // Written flags: cleared by reset or clr, set by a write.
   always_ff @(posedge CS or posedge cen) begin
      if (cen) begin
         for (int k = 0; k < NCH; k++) r_wf[k] <= '0;
      end else if (bus.clr) begin
         for (int k = 0; k < NCH; k++) r_wf[k] <= '0;
      end else if (bus.wr_en) begin
         for (int k = 0; k < NCH; k++) begin
            if (bus.wr_ch == CHW'(k))
               r_wf[k][bus.wr_addr] <= 1'b1;
         end
      end
   end

   // Pre-edge read of all channels; unwritten entries give defaults.
   always_comb begin
      w_rword = '0;
      for (int k = 0; k < NCH; k++) begin
         if (r_wf[k][w_raddr])
            w_rword[k*DATA_W +: DATA_W] = r_mem[k][w_raddr];
         else if (w_raddr != '0)
            w_rword[k*DATA_W +: DATA_W] = DEF_VAL;
      end
   end

   // Burst FSM and output registers.
   always_ff @(posedge CS or posedge cen) begin
      if (cen) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_rem   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_addr  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_ptr   <= w_ptr_n;
         r_rem   <= w_rem_n;
         r_valid <= w_valid_n;
         r_data  <= w_data_n;
         r_addr  <= w_addr_n;
         r_done  <= w_done_n;
      end
   end

   // Next state: load base on start, advance on handshake, drain in LAST.
   always_comb begin
      w_state_n = r_state;
      w_ptr_n   = r_ptr;
      w_rem_n   = r_rem;
      w_valid_n = r_valid;
      w_data_n  = r_data;
      w_addr_n  = r_addr;
      w_done_n  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.len == '0) begin
                  w_done_n = 1'b1;
               end else begin
                  w_data_n  = w_rword;
                  w_addr_n  = bus.base;
                  w_valid_n = 1'b1;
                  w_ptr_n   = bus.base + ADDR_W'(1);
                  w_rem_n   = bus.len - (ADDR_W+1)'(1);
                  w_state_n = (bus.len == (ADDR_W+1)'(1)) ? S_LAST : S_RUN;
               end
            end
         end
         S_RUN: begin
            if (r_valid && bus.rd_ready) begin
               w_data_n = w_rword;
               w_addr_n = r_ptr;
               w_ptr_n  = r_ptr + ADDR_W'(1);
               w_rem_n  = r_rem - (ADDR_W+1)'(1);
               if (r_rem == (ADDR_W+1)'(1))
                  w_state_n = S_LAST;
            end
         end
         S_LAST: begin
            if (bus.rd_ready) begin
               w_valid_n = 1'b0;
               w_done_n  = 1'b1;
               w_state_n = S_IDLE;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   assign bus.rd_valid = r_valid;
   assign bus.rd_data  = r_data;
   assign bus.rd_addr  = r_addr;
   assign bus.done     = r_done;
   assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_wo_bank.sv
// Directed bench for wo_bank (NCH=2): expected words are queued by
// the stimulus and checked by a monitor at each handshake.
module tb_wo_bank;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int NC = 2;

   typedef struct packed {
      logic [AW-1:0]    a;
      logic [NC*DW-1:0] d;
   } exp_t;

   logic CS  = 1'b0;
   logic cen = 1'b0;

   wo_bank_if #(.DATA_W(DW), .ADDR_W(AW), .NCH(NC)) bus ();

   wo_bank #(
      .DATA_W(DW), .ADDR_W(AW), .NCH(NC), .DEF_VAL(8'h02)
   ) dut (
      .CS(CS),
      .cen(cen),
      .bus(bus)
   );

   always #5 CS = ~CS;

   exp_t             exp_q[$];
   exp_t             e_pop;
   int               n_chk  = 0;
   int               n_fail = 0;
   int               n_done = 0;
   bit               prev_hs = 1'b0;
   bit               zl      = 1'b0;
   bit               hold    = 1'b0;
   logic [NC*DW-1:0] h_d;
   logic [AW-1:0]    h_a;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req,
                  $time);
      end
   endtask

   // Monitor: stall stability, done timing, scoreboard pop per handshake.
   always @(negedge CS) begin
      if (!cen) begin
         if (bus.done) begin
            n_done++;
            chk("done_timing", {31'd0, (prev_hs || zl)}, 32'd1);
            zl = 1'b0;
         end
         if (hold) begin
            chk("stall_valid", {31'd0, bus.rd_valid}, 32'd1);
            chk("stall_data", {16'd0, bus.rd_data}, {16'd0, h_d});
            chk("stall_addr", {24'd0, bus.rd_addr}, {24'd0, h_a});
         end
         hold = bus.rd_valid && !bus.rd_ready;
         h_d  = bus.rd_data;
         h_a  = bus.rd_addr;
         prev_hs = 1'b0;
         if (bus.rd_valid && bus.rd_ready) begin
            prev_hs = 1'b1;
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL extra_word actual=%h@%h required=none",
                        bus.rd_data, bus.rd_addr);
            end else begin
               e_pop = exp_q.pop_front();
               if (bus.rd_data !== e_pop.d || bus.rd_addr !== e_pop.a) begin
                  n_fail++;
                  $display("FAIL rd_word actual=%h@%h required=%h@%h",
                           bus.rd_data, bus.rd_addr, e_pop.d, e_pop.a);
               end
            end
         end
      end else begin
         hold    = 1'b0;
         prev_hs = 1'b0;
      end
   end

   task automatic tick();
      @(posedge CS);
      #1;
   endtask

   task automatic push(input int a, input int d);
      exp_t e;
      e.a = AW'(a);
      e.d = (NC*DW)'(d);
      exp_q.push_back(e);
   endtask

   task automatic wr(input int ch, input int a, input int d);
      bus.wr_en   = 1'b1;
      bus.wr_ch   = 1'(ch);
      bus.wr_addr = AW'(a);
      bus.wr_data = DW'(d);
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic start_b(input int b, input int l);
      bus.start = 1'b1;
      bus.base  = AW'(b);
      bus.len   = (AW+1)'(l);
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int d0;
      d0 = n_done;
      for (int i = 0; i < 600; i++) begin
         if (n_done > d0) break;
         tick();
      end
      tick();
      chk(nm, n_done - d0, 32'd1);
      chk({nm, "_queue"}, exp_q.size(), 32'd0);
      chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      int d0;
      bit found;
      bus.clr = 1'b0; bus.wr_en = 1'b0; bus.wr_ch = '0;
      bus.wr_addr = '0; bus.wr_data = '0; bus.start = 1'b0;
      bus.base = '0; bus.len = '0; bus.rd_ready = 1'b1;

      #1 cen = 1'b1;
      #1;
      chk("rst_valid", {31'd0, bus.rd_valid}, 32'd0);
      chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
      chk("rst_done",  {31'd0, bus.done}, 32'd0);
      chk("rst_data",  {16'd0, bus.rd_data}, 32'd0);
      chk("rst_addr",  {24'd0, bus.rd_addr}, 32'd0);
      tick(); tick();
      cen = 1'b0;
      tick();

      // Fresh bank: 0 at address 0, DEF_VAL elsewhere.
      push(0, 'h0000); push(1, 'h0202); push(2, 'h0202);
      start_b(0, 3);
      wait_done("b0_done");

      // Wrap past DEPTH-1.
      wr(0, 'hFF, 'h5A);
      push('hFE, 'h0202); push('hFF, 'h025A); push('h00, 'h0000);
      start_b('hFE, 3);
      wait_done("wrap_done");

      // Channel 1 lane.
      wr(1, 5, 'h33);
      push(5, 'h3302);
      start_b(5, 1);
      wait_done("ch1_done");

      // Stall three cycles on the second word.
      for (int i = 0; i < 4; i++) wr(0, 'h10 + i, 'h10 + i);
      for (int i = 0; i < 4; i++) push('h10 + i, 'h0210 + i);
      start_b('h10, 4);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.rd_valid && bus.rd_addr == 8'h11) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("stall_reach", {31'd0, found}, 32'd1);
      bus.rd_ready = 1'b0;
      tick(); tick(); tick();
      bus.rd_ready = 1'b1;
      wait_done("stall_done");

      // Same-edge write and burst read: old value first.
      bus.wr_en = 1'b1; bus.wr_ch = 1'b0;
      bus.wr_addr = 8'h20; bus.wr_data = 8'h77;
      push('h20, 'h0202);
      start_b('h20, 1);
      bus.wr_en = 1'b0;
      wait_done("rbw_done");
      push('h20, 'h0277);
      start_b('h20, 1);
      wait_done("rbw2_done");

      // clr beats a coincident write and wipes earlier ones.
      wr(0, 'h30, 'h44);
      push('h30, 'h0244);
      start_b('h30, 1);
      wait_done("clr_pre_done");
      bus.clr = 1'b1;
      wr(0, 'h31, 'h55);
      bus.clr = 1'b0;
      push('h30, 'h0202); push('h31, 'h0202);
      start_b('h30, 2);
      wait_done("clr_done");

      // len > DEPTH: addresses repeat.
      for (int i = 0; i < 258; i++) begin
         if (((i + 'hFE) & 'hFF) == 0) push(0, 'h0000);
         else push((i + 'hFE) & 'hFF, 'h0202);
      end
      start_b('hFE, 258);
      wait_done("long_done");

      // Zero-length burst.
      zl = 1'b1;
      start_b('h50, 0);
      chk("len0_busy",  {31'd0, bus.busy}, 32'd0);
      chk("len0_valid", {31'd0, bus.rd_valid}, 32'd0);
      wait_done("len0_done");

      // start while busy is ignored.
      push('h40, 'h0202); push('h41, 'h0202); push('h42, 'h0202);
      start_b('h40, 3);
      start_b('h80, 5);
      wait_done("busy_done");
      tick(); tick();
      chk("busy_ignored_q", exp_q.size(), 32'd0);

      // Reset mid-burst: immediate drop, no done, flags cleared.
      wr(0, 'h60, 'h66);
      push('h60, 'h0266);
      start_b('h60, 1);
      wait_done("pre_rst_done");
      push(0, 'h0000);
      for (int i = 1; i < 10; i++) push(i, 'h0202);
      start_b(0, 10);
      tick(); tick();
      cen = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, bus.rd_valid}, 32'd0);
      chk("mid_rst_busy",  {31'd0, bus.busy}, 32'd0);
      chk("mid_rst_data",  {16'd0, bus.rd_data}, 32'd0);
      exp_q.delete();
      d0 = n_done;
      tick(); tick();
      cen = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("mid_rst_nodone", n_done - d0, 32'd0);
      push('h60, 'h0202);
      start_b('h60, 1);
      wait_done("post_rst_done");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
